axis_fb_pixel_packer: RTL and testbench
=======================================

Name: axis_fb_pixel_packer

Overview:
- Sits directly upstream of the framebuffer writer stage.
- Accepts a 16-bit-per-pixel colour stream from the rasterizer display path and packs it into DATA_WIDTH stream beats, marking the last beat of each frame with tlast.
- Sequences the writer's commit handshake (commit_fb / fb_addr / fb_size / fb_committed) once per frame.
- Reports completion to the control logic with a single-cycle done pulse.

Parameters:
- DATA_WIDTH, 32, output stream width; integer multiple of 16, at least 16.
- ADDR_WIDTH, 32, framebuffer address width.
- FB_SIZE_IN_PIXEL_LG, 20, width of the pixel-count fields.
- PIXEL_PER_BEAT, DATA_WIDTH/16, derived (localparam); pixels per output beat.

Ports:
- aclk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- start_addr  in  ADDR_WIDTH  framebuffer base address
- frame_pixels  in  FB_SIZE_IN_PIXEL_LG  frame size in 16-bit pixels
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse at frame completion
- commit_fb  out  1  commit request to the writer
- fb_addr  out  ADDR_WIDTH  latched start_addr
- fb_size  out  FB_SIZE_IN_PIXEL_LG  latched frame_pixels
- fb_committed  in  1  writer acknowledge; low while the writer is taking the command
- s_pix_axis_tvalid  in  1  pixel valid
- s_pix_axis_tready  out  1  pixel ready
- s_pix_axis_tdata  in  16  pixel
- m_disp_axis_tvalid  out  1  beat valid
- m_disp_axis_tready  in  1  beat ready
- m_disp_axis_tlast  out  1  final beat of the frame
- m_disp_axis_tdata  out  DATA_WIDTH  packed pixels

Behaviour:
- Reset (async assert, sync release) values:
  - busy=0, done=0, commit_fb=0, m_disp_axis_tvalid=0, m_disp_axis_tlast=0, s_pix_axis_tready=0.
  - fb_addr=0, fb_size=0, pixel counter=0, pack slot=0, state=IDLE.
- IDLE:
  - start with frame_pixels!=0: latch start_addr into fb_addr and frame_pixels into fb_size; load remaining=frame_pixels; commit_fb<=1; go to COMMIT.
  - start with frame_pixels==0: done pulses the next cycle; no commit; stay IDLE.
- COMMIT:
  - Hold commit_fb=1 until fb_committed is sampled 0, then commit_fb<=0 and go to STREAM.
  - fb_committed already 0 on entry (previous frame's commit still in progress): keep holding until a 1->0 transition is seen.
- STREAM:
  - s_pix_axis_tready=1 iff remaining>0 and the accepted pixel can be placed: the current slot is not the last slot of a beat, or the output register is empty or being drained this cycle (m_disp_axis_tready & tvalid).
  - Packing is little-endian: the first pixel goes in bits [15:0], the next in [31:16], and so on.
  - On each accepted pixel, remaining decrements. When the slot reaches PIXEL_PER_BEAT-1, or remaining becomes 0, the packed word moves to the output register in the same edge and the slot resets to 0.
  - A partial final beat has its unused lanes zero-padded.
  - The output register sets tlast=1 on the beat created when remaining reaches 0.
  - Sustained throughput is 1 pixel/cycle with m_disp_axis_tready constantly high. Latency from the last pixel of a beat to m_disp_axis_tvalid is 1 cycle.
  - The output register obeys AXIS rules: tdata/tlast stable while tvalid & !tready; tvalid never drops without a handshake.
  - On handshake of the tlast beat, go to FINISH.
- FINISH:
  - When fb_committed==1, pulse done for 1 cycle and go to IDLE.
  - If fb_committed is already 1 (the writer's early acknowledge), done follows in the next cycle.
- busy=1 in COMMIT, STREAM and FINISH.
- The s_pix_axis_tlast-free interface is deliberate: the frame length comes only from frame_pixels; excess input pixels stay blocked (tready=0) after remaining reaches 0.
- Reset mid-frame: all state clears immediately; the pending output beat is discarded; the downstream writer is expected to be reset together with this block.

Test Plan:
1. DATA_WIDTH=32, frame_pixels=4, pixels 0x1111,0x2222,0x3333,0x4444, tready=1 -> commit_fb held until fb_committed drops, fb_size=4; beats 0x22221111, then 0x44443333 with tlast=1; done pulses once.
2. frame_pixels=3 -> beats 0x22221111, then 0x00003333 with tlast=1; s_pix_axis_tready=0 after the third pixel.
3. m_disp_axis_tready held 0 for 5 cycles mid-frame -> tdata/tlast stable, s_pix_axis_tready drops when the pack slot is full, no pixel lost or duplicated (scoreboard over 1000 random pixels with random valid/ready).
4. start with frame_pixels=0 -> no commit_fb, done pulses the next cycle, busy stays 0.
5. Writer holds fb_committed=1 late (10 cycles after commit) -> commit_fb remains 1 throughout, stream begins only after fb_committed is seen low.
6. resetn asserted during STREAM -> all outputs take their reset values asynchronously; a following frame of 2 pixels completes correctly.

Source files
------------

// File: rtl/axis_fb_pixel_packer.sv
// Packs a 16-bit pixel stream into DATA_WIDTH AXI-Stream beats, one frame at a time,
// and sequences the framebuffer writer's commit handshake around each frame.
module axis_fb_pixel_packer #(
    parameter int DATA_WIDTH          = 32,
    parameter int ADDR_WIDTH          = 32,
    parameter int FB_SIZE_IN_PIXEL_LG = 20
) (
    input  logic                           aclk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          start_addr,
    input  logic [FB_SIZE_IN_PIXEL_LG-1:0] frame_pixels,
    output logic                           busy,
    output logic                           done,
    output logic                           commit_fb,
    output logic [ADDR_WIDTH-1:0]          fb_addr,
    output logic [FB_SIZE_IN_PIXEL_LG-1:0] fb_size,
    input  logic                           fb_committed,
    input  logic                           s_pix_axis_tvalid,
    output logic                           s_pix_axis_tready,
    input  logic [15:0]                    s_pix_axis_tdata,
    output logic                           m_disp_axis_tvalid,
    input  logic                           m_disp_axis_tready,
    output logic                           m_disp_axis_tlast,
    output logic [DATA_WIDTH-1:0]          m_disp_axis_tdata
);
    localparam int PIXEL_PER_BEAT = DATA_WIDTH / 16;
    localparam int SLOT_W         = (PIXEL_PER_BEAT > 1) ? $clog2(PIXEL_PER_BEAT) : 1;
    localparam logic [FB_SIZE_IN_PIXEL_LG-1:0] ONE_PIX = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMMIT,
        S_STREAM,
        S_FINISH
    } state_t;

    state_t                         state_q, state_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           commit_q, commit_d;
    logic                           seen_hi_q, seen_hi_d;
    logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic [FB_SIZE_IN_PIXEL_LG-1:0] size_q, size_d;
    logic [FB_SIZE_IN_PIXEL_LG-1:0] remain_q, remain_d;
    logic [SLOT_W-1:0]              slot_q, slot_d;
    logic [DATA_WIDTH-1:0]          pack_q, pack_d;
    logic                           ovalid_q, ovalid_d;
    logic                           olast_q, olast_d;
    logic [DATA_WIDTH-1:0]          odata_q, odata_d;

    logic                  last_lane;
    logic                  final_pix;
    logic                  out_free;
    logic                  pix_ready;
    logic                  pix_fire;
    logic                  out_fire;
    logic [DATA_WIDTH-1:0] word;

    // Both streams transfer on a cycle where valid & ready are high; a source holds
    // valid and its payload stable until that happens.  A pixel that completes a beat
    // (full lane set or frame end) needs the output register free or draining now.
    assign last_lane = (slot_q == SLOT_W'(PIXEL_PER_BEAT - 1));
    assign final_pix = (remain_q == ONE_PIX);
    assign out_free  = !ovalid_q || m_disp_axis_tready;
    assign pix_ready = (state_q == S_STREAM) && (remain_q != '0) &&
                       ((!last_lane && !final_pix) || out_free);
    assign pix_fire  = pix_ready && s_pix_axis_tvalid;
    assign out_fire  = ovalid_q && m_disp_axis_tready;

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        commit_d  = commit_q;
        seen_hi_d = seen_hi_q;
        addr_d    = addr_q;
        size_d    = size_q;
        remain_d  = remain_q;
        slot_d    = slot_q;
        pack_d    = pack_q;
        ovalid_d  = ovalid_q;
        olast_d   = olast_q;
        odata_d   = odata_q;

        word = pack_q;
        for (int i = 0; i < PIXEL_PER_BEAT; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                word[i*16 +: 16] = s_pix_axis_tdata;
            end
        end

        if (out_fire) begin
            ovalid_d = 1'b0;
            olast_d  = 1'b0;
        end

        // Lanes above the current slot are always zero, which pads a short final beat.
        if (pix_fire) begin
            remain_d = remain_q - ONE_PIX;
            if (last_lane || final_pix) begin
                ovalid_d = 1'b1;
                olast_d  = final_pix;
                odata_d  = word;
                pack_d   = '0;
                slot_d   = '0;
            end else begin
                pack_d = word;
                slot_d = slot_q + SLOT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (frame_pixels != '0) begin
                        addr_d    = start_addr;
                        size_d    = frame_pixels;
                        remain_d  = frame_pixels;
                        slot_d    = '0;
                        pack_d    = '0;
                        commit_d  = 1'b1;
                        seen_hi_d = 1'b0;
                        state_d   = S_COMMIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                // Only a high-to-low edge of fb_committed acknowledges this commit.
                if (fb_committed) begin
                    seen_hi_d = 1'b1;
                end else if (seen_hi_q) begin
                    commit_d = 1'b0;
                    state_d  = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_fire && olast_q) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (fb_committed) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_d = (state_d != S_IDLE);

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            commit_q  <= 1'b0;
            seen_hi_q <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            remain_q  <= '0;
            slot_q    <= '0;
            pack_q    <= '0;
            ovalid_q  <= 1'b0;
            olast_q   <= 1'b0;
            odata_q   <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            commit_q  <= commit_d;
            seen_hi_q <= seen_hi_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            remain_q  <= remain_d;
            slot_q    <= slot_d;
            pack_q    <= pack_d;
            ovalid_q  <= ovalid_d;
            olast_q   <= olast_d;
            odata_q   <= odata_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign commit_fb          = commit_q;
    assign fb_addr            = addr_q;
    assign fb_size            = size_q;
    assign s_pix_axis_tready  = pix_ready;
    assign m_disp_axis_tvalid = ovalid_q;
    assign m_disp_axis_tlast  = olast_q;
    assign m_disp_axis_tdata  = odata_q;
endmodule

// File: tb/tb_axis_fb_pixel_packer.sv
// Scoreboard bench for axis_fb_pixel_packer: directed frames, a writer model for the
// commit handshake, and a monitor that checks every output beat against a queue.
module tb_axis_fb_pixel_packer;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int SW  = 20;
    localparam int PPB = DW / 16;

    logic          aclk = 1'b0;
    logic          resetn;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [SW-1:0] frame_pixels;
    logic          busy, done, commit_fb;
    logic [AW-1:0] fb_addr;
    logic [SW-1:0] fb_size;
    logic          fb_committed;
    logic          s_tvalid, s_tready;
    logic [15:0]   s_tdata;
    logic          m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;

    axis_fb_pixel_packer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FB_SIZE_IN_PIXEL_LG(SW)) dut (
        .aclk(aclk), .resetn(resetn), .start(start), .start_addr(start_addr),
        .frame_pixels(frame_pixels), .busy(busy), .done(done), .commit_fb(commit_fb),
        .fb_addr(fb_addr), .fb_size(fb_size), .fb_committed(fb_committed),
        .s_pix_axis_tvalid(s_tvalid), .s_pix_axis_tready(s_tready), .s_pix_axis_tdata(s_tdata),
        .m_disp_axis_tvalid(m_tvalid), .m_disp_axis_tready(m_tready),
        .m_disp_axis_tlast(m_tlast), .m_disp_axis_tdata(m_tdata)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW:0] exp_q[$];
    logic [15:0] px_q[$];
    int pix_idx = 0;
    int done_cnt = 0;
    int done_base = 0;
    int ready_mode = 0;
    int stall_left = 0;
    int stall_acc = 0;
    bit in_stall = 0;
    int wr_ack_delay = 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Writer model: drops fb_committed a while after seeing a commit, then restores it.
    initial begin
        fb_committed = 1'b1;
        forever begin
            @(posedge aclk); #1;
            if (resetn && commit_fb && fb_committed) begin
                repeat (wr_ack_delay) begin @(posedge aclk); #1; end
                fb_committed = 1'b0;
                repeat (3) begin @(posedge aclk); #1; end
                fb_committed = 1'b1;
            end
        end
    end

    // Downstream ready driver with an optional forced stall window.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            if (stall_left > 0) begin
                m_tready = 1'b0;
                in_stall = 1'b1;
                stall_left--;
            end else begin
                if (in_stall) begin
                    check("stall_accept_bound", 64'(stall_acc <= 2 * PPB - 1), 64'd1);
                    in_stall  = 1'b0;
                    stall_acc = 0;
                end
                m_tready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Output monitor: scoreboard pops, AXIS stability and done pulse width.
    logic          stall_prev = 1'b0;
    logic [DW:0]   held_beat;
    logic          done_prev = 1'b0;
    always @(negedge aclk) begin
        if (!resetn) begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                check("tvalid_held", 64'(m_tvalid), 64'd1);
                check("beat_stable", 64'({m_tlast, m_tdata}), 64'(held_beat));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none", {m_tlast, m_tdata});
                end else begin
                    check("beat", 64'({m_tlast, m_tdata}), 64'(exp_q.pop_front()));
                end
            end
            stall_prev = m_tvalid && !m_tready;
            held_beat  = {m_tlast, m_tdata};
            if (in_stall && s_tvalid && s_tready) stall_acc++;
            if (done) begin
                done_cnt++;
                if (done_prev) check("done_single_cycle", 64'(done_prev), 64'd0);
            end
            done_prev = done;
        end
    end

    task automatic push_expected(input int n);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++) begin
            w[(i % PPB) * 16 +: 16] = px_q[i];
            if ((i % PPB) == PPB - 1 || i == n - 1) begin
                exp_q.push_back({1'(i == n - 1), w});
                w = '0;
            end
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] addr, input int n);
        start        = 1'b1;
        start_addr   = addr;
        frame_pixels = SW'(n);
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic start_frame(input logic [AW-1:0] addr, input int n, output int hold);
        int viol;
        int guard;
        pix_idx   = 0;
        done_base = done_cnt;
        push_expected(n);
        pulse_start(addr, n);
        check("commit_after_start", 64'(commit_fb), 64'd1);
        check("fb_size_latched", 64'(fb_size), 64'(n));
        check("fb_addr_latched", 64'(fb_addr), 64'(addr));
        check("busy_after_start", 64'(busy), 64'd1);
        hold = 0; viol = 0; guard = 0;
        forever begin
            @(negedge aclk);
            if (!commit_fb) break;
            hold++;
            if (s_tready) viol++;
            guard++;
            if (guard > 500) begin
                check("commit_timeout", 64'd1, 64'd0);
                break;
            end
        end
        check("no_pixel_during_commit", 64'(viol), 64'd0);
        check("commit_drop_after_ack", 64'(fb_committed), 64'd0);
        @(posedge aclk); #1;
    endtask

    task automatic drive_pixels(input int k, input int gap_max, input int stall_at);
        int gap;
        int budget;
        logic hs;
        for (int i = 0; i < k; i++) begin
            gap = $urandom_range(0, gap_max);
            s_tvalid = 1'b0;
            repeat (gap) begin @(posedge aclk); #1; end
            if (i == stall_at) stall_left = 5;
            s_tvalid = 1'b1;
            s_tdata  = px_q[pix_idx];
            budget   = 0;
            forever begin
                @(negedge aclk);
                hs = s_tready;
                @(posedge aclk); #1;
                if (hs) break;
                budget++;
                if (budget > 2000) begin
                    check("pixel_accept_timeout", 64'd1, 64'd0);
                    break;
                end
            end
            pix_idx++;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (done_cnt == done_base && guard < 5000) begin
            @(posedge aclk); #1;
            guard++;
        end
        check("done_seen", 64'(done_cnt > done_base), 64'd1);
        repeat (3) begin @(posedge aclk); #1; end
        check("done_once", 64'(done_cnt - done_base), 64'd1);
        check("idle_after_done", 64'(busy), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int hold;
        #100_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        resetn = 1'b0; start = 1'b0; start_addr = '0; frame_pixels = '0;
        s_tvalid = 1'b0; s_tdata = '0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_commit", 64'(commit_fb), 64'd0);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_fb_addr", 64'(fb_addr), 64'd0);
        check("rst_fb_size", 64'(fb_size), 64'd0);
        resetn = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end

        // Full 4-pixel frame, two full beats.
        px_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        start_frame(32'h1000_0000, 4, hold);
        drive_pixels(4, 0, -1);
        wait_done();

        // 3-pixel frame: padded last beat, excess pixel stays blocked.
        px_q = '{16'h1111, 16'h2222, 16'h3333};
        start_frame(32'h2000_0040, 3, hold);
        drive_pixels(3, 1, -1);
        s_tvalid = 1'b1;
        s_tdata  = 16'hDEAD;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("excess_pixel_blocked", 64'(s_tready), 64'd0);
        end
        s_tvalid = 1'b0;
        wait_done();

        // 1000 random pixels with random gaps/backpressure and a 5-cycle stall.
        px_q.delete();
        for (int i = 0; i < 1000; i++) px_q.push_back(16'($urandom_range(0, 16'hFFFF)));
        ready_mode = 1;
        start_frame(32'h3000_0000, 1000, hold);
        drive_pixels(1000, 2, 500);
        wait_done();
        ready_mode = 0;

        // Zero-length frame: done next cycle, no commit.
        done_base = done_cnt;
        pulse_start(32'h4000_0000, 0);
        check("zero_done_pulse", 64'(done), 64'd1);
        check("zero_no_commit", 64'(commit_fb), 64'd0);
        check("zero_not_busy", 64'(busy), 64'd0);
        @(posedge aclk); #1;
        check("zero_done_cleared", 64'(done), 64'd0);
        check("zero_still_idle", 64'(busy), 64'd0);
        check("zero_done_count", 64'(done_cnt - done_base), 64'd1);

        // Late writer acknowledge: commit must hold for the whole delay.
        wr_ack_delay = 10;
        px_q = '{16'h5555, 16'h6666};
        start_frame(32'h5000_0000, 2, hold);
        check("late_ack_commit_hold", 64'(hold >= 10), 64'd1);
        drive_pixels(2, 0, -1);
        wait_done();
        wr_ack_delay = 2;

        // Reset in the middle of a stream, then a clean 2-pixel frame.
        px_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707, 16'h0808};
        start_frame(32'h6000_0000, 8, hold);
        drive_pixels(3, 0, -1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_commit", 64'(commit_fb), 64'd0);
        check("midrst_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_tlast", 64'(m_tlast), 64'd0);
        check("midrst_tready", 64'(s_tready), 64'd0);
        check("midrst_fb_size", 64'(fb_size), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1 resetn = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end
        px_q = '{16'hAAAA, 16'hBBBB};
        start_frame(32'h7000_0000, 2, hold);
        drive_pixels(2, 0, -1);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
